// File: rtl/motor_pkg.sv
// Shared types for the six-step commutation sequencer: sector encoding,
// FSM states, hall decoding and the gate drive tables.
package motor_pkg;

    typedef logic [2:0] sector_t;

    localparam sector_t SECTOR_INVALID = 3'd7;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DEAD,
        ST_DRIVE,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [2:0] h;
        logic [2:0] l;
    } gates_t;

    function automatic sector_t decode_hall(input logic [2:0] code);
        case (code)
            3'b101:  return 3'd0;
            3'b100:  return 3'd1;
            3'b110:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            3'b001:  return 3'd5;
            default: return SECTOR_INVALID;
        endcase
    endfunction

    function automatic sector_t sector_inc(input sector_t s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic sector_t sector_dec(input sector_t s);
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

    // Bit 0 = phase A, bit 1 = B, bit 2 = C; exactly one high and one low side.
    function automatic gates_t drive_pattern(input sector_t s, input logic dir);
        gates_t g;
        g = '0;
        if (dir) begin
            case (s)
                3'd0: g = '{h: 3'b100, l: 3'b010};
                3'd1: g = '{h: 3'b001, l: 3'b010};
                3'd2: g = '{h: 3'b001, l: 3'b100};
                3'd3: g = '{h: 3'b010, l: 3'b100};
                3'd4: g = '{h: 3'b010, l: 3'b001};
                3'd5: g = '{h: 3'b100, l: 3'b001};
                default: g = '0;
            endcase
        end else begin
            case (s)
                3'd0: g = '{h: 3'b010, l: 3'b100};
                3'd1: g = '{h: 3'b010, l: 3'b001};
                3'd2: g = '{h: 3'b100, l: 3'b001};
                3'd3: g = '{h: 3'b100, l: 3'b010};
                3'd4: g = '{h: 3'b001, l: 3'b010};
                3'd5: g = '{h: 3'b001, l: 3'b100};
                default: g = '0;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/commutation_sequencer_if.sv
// Control/status bundle between the motor controller logic and the
// commutation sequencer.
interface commutation_sequencer_if;
    import motor_pkg::*;

    logic [2:0]         hall;
    logic               enable;
    logic               dir;
    logic               fault_n;
    logic               clear_fault;
    logic [2:0]         gate_h;
    logic [2:0]         gate_l;
    sector_t            sector;
    logic signed [31:0] hall_position;
    logic               hall_error;
    logic               stall;
    logic               fault;

    modport master (
        output hall, enable, dir, fault_n, clear_fault,
        input  gate_h, gate_l, sector, hall_position, hall_error, stall, fault
    );

    modport slave (
        input  hall, enable, dir, fault_n, clear_fault,
        output gate_h, gate_l, sector, hall_position, hall_error, stall, fault
    );

endinterface

// File: rtl/hall_filter.sv
// Hall sensor front end: 2-flop synchronizer, stability filter and decoder.
// sector_changed pulses for one cycle alongside each new accepted sector.
module hall_filter
    import motor_pkg::*;
#(
    parameter int HALL_FILTER = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] hall,
    output sector_t    sector,
    output logic       sector_changed
);

    localparam int              CW       = (HALL_FILTER > 1) ? $clog2(HALL_FILTER) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(HALL_FILTER - 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;
    logic [CW-1:0] stable_cnt;
    sector_t       decoded;

    assign decoded = decode_hall(cand);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1          <= '0;
            sync2          <= '0;
            cand           <= '0;
            stable_cnt     <= '0;
            sector         <= SECTOR_INVALID;
            sector_changed <= 1'b0;
        end else begin
            sync1          <= hall;
            sync2          <= sync1;
            sector_changed <= 1'b0;
            if (sync2 != cand) begin
                cand       <= sync2;
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_LAST) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else if (decoded != sector) begin
                sector         <= decoded;
                sector_changed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation controller: OFF/DEAD/DRIVE/FAULT sequencing,
// dead-time and stall counters, hall position tracking and sticky flags.
module commutation_sequencer
    import motor_pkg::*;
#(
    parameter int DEADTIME      = 64,
    parameter int HALL_FILTER   = 16,
    parameter int STALL_TIMEOUT = 16_000_000
) (
    input logic                    CLK,
    input logic                    reset,
    commutation_sequencer_if.slave bus
);

    localparam int            DW         = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int            SW         = $clog2(STALL_TIMEOUT + 1);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEADTIME - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_TIMEOUT);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

    sector_t            sector;
    sector_t            last_sector;
    sector_t            lat_sector;
    logic               sector_changed;
    logic               fault_s1, fault_s2;
    logic               dir_q, lat_dir;
    state_t             state, state_next;
    logic [DW-1:0]      dead_cnt;
    logic [SW-1:0]      stall_cnt;
    logic               dead_load, latch_drive, counting, stall_hit;
    logic               step_fwd, step_rev, err_set;
    gates_t             gates_next;
    logic [2:0]         gate_h, gate_l;
    logic signed [31:0] position;
    logic               hall_error, stall, fault;

    hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall_filter (
        .CLK            (CLK),
        .reset          (reset),
        .hall           (bus.hall),
        .sector         (sector),
        .sector_changed (sector_changed)
    );

    assign counting  = (state == ST_DEAD) || (state == ST_DRIVE);
    // Fault fires on the cycle the counter would reach STALL_TIMEOUT.
    assign stall_hit = counting && !sector_changed && (stall_cnt >= STALL_LAST);

    // NOTE: every output of a combinational block gets a default first, so no latches.
    always_comb begin
        state_next  = state;
        dead_load   = 1'b0;
        latch_drive = 1'b0;
        if (!fault_s2 || stall_hit) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_OFF: begin
                    if (bus.enable && sector != SECTOR_INVALID) begin
                        state_next = ST_DEAD;
                        dead_load  = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (!bus.enable || sector == SECTOR_INVALID) begin
                        state_next = ST_OFF;
                    end else if (sector_changed || bus.dir != dir_q) begin
                        dead_load = 1'b1;
                    end else if (dead_cnt == '0) begin
                        state_next  = ST_DRIVE;
                        latch_drive = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!bus.enable || sector == SECTOR_INVALID) begin
                        state_next = ST_OFF;
                    end else if (sector != lat_sector || bus.dir != lat_dir) begin
                        state_next = ST_DEAD;
                        dead_load  = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (bus.clear_fault) state_next = ST_OFF;
                end
                default: state_next = ST_OFF;
            endcase
        end
    end

    // Staying in DRIVE implies sector/dir equal the latched pair.
    assign gates_next = (state_next == ST_DRIVE) ? drive_pattern(sector, bus.dir) : '0;

    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        err_set  = 1'b0;
        if (sector_changed) begin
            if (sector == SECTOR_INVALID) begin
                err_set = 1'b1;
            end else if (last_sector != SECTOR_INVALID) begin
                if (sector == sector_inc(last_sector))      step_fwd = 1'b1;
                else if (sector == sector_dec(last_sector)) step_rev = 1'b1;
                else                                        err_set  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fault_s1    <= 1'b1;
            fault_s2    <= 1'b1;
            state       <= ST_OFF;
            dead_cnt    <= '0;
            stall_cnt   <= '0;
            dir_q       <= 1'b0;
            lat_dir     <= 1'b0;
            lat_sector  <= SECTOR_INVALID;
            last_sector <= SECTOR_INVALID;
            gate_h      <= '0;
            gate_l      <= '0;
            position    <= '0;
            hall_error  <= 1'b0;
            stall       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            fault_s1    <= bus.fault_n;
            fault_s2    <= fault_s1;
            state       <= state_next;
            dir_q       <= bus.dir;
            last_sector <= sector;
            gate_h      <= gates_next.h;
            gate_l      <= gates_next.l;
            fault       <= (state_next == ST_FAULT);

            if (dead_load)                              dead_cnt <= DEAD_LOAD;
            else if (state == ST_DEAD && dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;

            if (!counting || sector_changed) stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;

            if (latch_drive) begin
                lat_sector <= sector;
                lat_dir    <= bus.dir;
            end

            if (step_fwd)      position <= position + 32'sd1;
            else if (step_rev) position <= position - 32'sd1;

            if (err_set)              hall_error <= 1'b1;
            else if (bus.clear_fault) hall_error <= 1'b0;

            if (stall_hit)            stall <= 1'b1;
            else if (bus.clear_fault) stall <= 1'b0;
        end
    end

    assign bus.gate_h        = gate_h;
    assign bus.gate_l        = gate_l;
    assign bus.sector        = sector;
    assign bus.hall_position = position;
    assign bus.hall_error    = hall_error;
    assign bus.stall         = stall;
    assign bus.fault         = fault;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed bench for commutation_sequencer: table-driven forward rotation plus
// hand sequences for glitch, invalid/skip, fault, stall, direction and reset.
module tb_commutation_sequencer;

    localparam int DEADTIME      = 64;
    localparam int HALL_FILTER   = 16;
    localparam int STALL_TIMEOUT = 1000;

    typedef struct {
        logic [2:0] hall;
        logic [2:0] sec;
        logic [2:0] gh;
        logic [2:0] gl;
        int         pos;
    } vec_t;

    logic CLK = 1'b0;
    logic reset;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   overlap = 0;

    commutation_sequencer_if bus ();

    commutation_sequencer #(
        .DEADTIME      (DEADTIME),
        .HALL_FILTER   (HALL_FILTER),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_clear();
        bus.clear_fault = 1'b1;
        @(negedge CLK);
        bus.clear_fault = 1'b0;
    endtask

    // Observation c is the negedge after the c-th posedge since the call.
    task automatic watch(input int budget, input logic [2:0] want_sec,
                         output int t_sec, output int t_off, output int t_on);
        t_sec = -1;
        t_off = -1;
        t_on  = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLK);
            if ((bus.gate_h & bus.gate_l) != 3'b000 ||
                $countones(bus.gate_h) > 1 || $countones(bus.gate_l) > 1)
                overlap++;
            if (t_sec < 0 && bus.sector == want_sec) t_sec = c;
            if (t_off < 0 && bus.gate_h == 3'b000 && bus.gate_l == 3'b000) t_off = c;
            else if (t_off > 0 && t_on < 0 && (bus.gate_h | bus.gate_l) != 3'b000) t_on = c;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   t_sec, t_off, t_on, t_fault;
        int   disturbed;

        vecs[0] = '{hall: 3'b101, sec: 3'd0, gh: 3'b100, gl: 3'b010, pos: 0};
        vecs[1] = '{hall: 3'b100, sec: 3'd1, gh: 3'b001, gl: 3'b010, pos: 1};
        vecs[2] = '{hall: 3'b110, sec: 3'd2, gh: 3'b001, gl: 3'b100, pos: 2};
        vecs[3] = '{hall: 3'b010, sec: 3'd3, gh: 3'b010, gl: 3'b100, pos: 3};
        vecs[4] = '{hall: 3'b011, sec: 3'd4, gh: 3'b010, gl: 3'b001, pos: 4};
        vecs[5] = '{hall: 3'b001, sec: 3'd5, gh: 3'b100, gl: 3'b001, pos: 5};

        reset           = 1'b1;
        bus.hall        = 3'b101;
        bus.enable      = 1'b0;
        bus.dir         = 1'b1;
        bus.fault_n     = 1'b1;
        bus.clear_fault = 1'b0;
        tick(3);
        check("rst_gate_h", bus.gate_h, 0);
        check("rst_gate_l", bus.gate_l, 0);
        check("rst_sector", bus.sector, 7);
        check("rst_position", bus.hall_position, 0);
        check("rst_hall_error", bus.hall_error, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_fault", bus.fault, 0);
        reset = 1'b0;

        tick(30);
        check("off_sector", bus.sector, 0);
        check("off_gates", {bus.gate_h, bus.gate_l}, 0);

        // enable rising: first drive observation DEADTIME+1 edges later
        bus.enable = 1'b1;
        watch(100, 3'd0, t_sec, t_off, t_on);
        check("enable_first_drive", t_on, DEADTIME + 1);
        check("enable_gate_h", bus.gate_h, vecs[0].gh);
        check("enable_gate_l", bus.gate_l, vecs[0].gl);

        // 10-cycle glitch shorter than the filter must not disturb anything
        disturbed = 0;
        bus.hall = 3'b100;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) bus.hall = 3'b101;
            @(negedge CLK);
            if (bus.sector != 3'd0 || bus.gate_h != 3'b100 || bus.gate_l != 3'b010)
                disturbed++;
        end
        check("glitch_disturbed_cycles", disturbed, 0);

        for (int i = 1; i < 6; i++) begin
            bus.hall = vecs[i].hall;
            watch(100, vecs[i].sec, t_sec, t_off, t_on);
            check($sformatf("rot%0d_sector_latency", i), t_sec, 2 + HALL_FILTER + 1);
            check($sformatf("rot%0d_gates_off", i), t_off, 2 + HALL_FILTER + 2);
            check($sformatf("rot%0d_dead_run", i), t_on - t_off, DEADTIME);
            check($sformatf("rot%0d_gate_h", i), bus.gate_h, vecs[i].gh);
            check($sformatf("rot%0d_gate_l", i), bus.gate_l, vecs[i].gl);
            check($sformatf("rot%0d_position", i), bus.hall_position, vecs[i].pos);
        end
        check("rot_hall_error", bus.hall_error, 0);

        // direction flip in sector 5: reverse table gives HA/LC
        bus.dir = 1'b0;
        watch(100, 3'd5, t_sec, t_off, t_on);
        check("dir_gates_off", t_off, 1);
        check("dir_dead_run", t_on - t_off, DEADTIME);
        check("dir_rev_gate_h", bus.gate_h, 3'b001);
        check("dir_rev_gate_l", bus.gate_l, 3'b100);
        bus.dir = 1'b1;
        watch(100, 3'd5, t_sec, t_off, t_on);
        check("dir_fwd_gate_h", bus.gate_h, 3'b100);

        // driver fault: 2 sync stages + 1 register
        bus.fault_n = 1'b0;
        tick(2);
        check("fault_obs2_gate_h", bus.gate_h, 3'b100);
        tick(1);
        check("fault_obs3_gates", {bus.gate_h, bus.gate_l}, 0);
        check("fault_obs3_fault", bus.fault, 1);
        pulse_clear();
        tick(1);
        check("fault_clear_ignored", bus.fault, 1);
        bus.fault_n = 1'b1;
        tick(4);
        check("fault_held_until_clear", bus.fault, 1);
        pulse_clear();
        check("fault_cleared", bus.fault, 0);
        watch(100, 3'd5, t_sec, t_off, t_on);
        // OFF->DEAD took one edge already counted inside this window
        check("fault_recover_drive", t_on, DEADTIME + 1);
        check("fault_recover_gate_l", bus.gate_l, 3'b001);

        // invalid code in DRIVE
        bus.hall = 3'b111;
        watch(30, 3'd7, t_sec, t_off, t_on);
        check("inv_sector_latency", t_sec, 2 + HALL_FILTER + 1);
        check("inv_gates_off", t_off, 2 + HALL_FILTER + 2);
        check("inv_hall_error", bus.hall_error, 1);
        pulse_clear();
        check("inv_error_cleared", bus.hall_error, 0);

        // 7 -> valid does not count; then skipped 0 -> 2
        bus.hall = 3'b101;
        watch(30, 3'd0, t_sec, t_off, t_on);
        check("from7_sector", t_sec, 2 + HALL_FILTER + 1);
        check("from7_position", bus.hall_position, 5);
        check("from7_hall_error", bus.hall_error, 0);
        bus.hall = 3'b110;
        watch(30, 3'd2, t_sec, t_off, t_on);
        check("skip_hall_error", bus.hall_error, 1);
        check("skip_position", bus.hall_position, 5);
        pulse_clear();
        tick(100);
        check("skip_drive_gate_h", bus.gate_h, 3'b001);
        check("skip_drive_gate_l", bus.gate_l, 3'b100);

        // enable low in DRIVE: gates off next cycle
        bus.enable = 1'b0;
        tick(1);
        check("disable_gates", {bus.gate_h, bus.gate_l}, 0);
        tick(2);

        // stall: STALL_TIMEOUT cycles in DEAD/DRIVE after the OFF->DEAD edge
        bus.enable = 1'b1;
        t_fault = -1;
        for (int c = 1; c <= STALL_TIMEOUT + 100 && t_fault < 0; c++) begin
            @(negedge CLK);
            if (bus.fault) t_fault = c;
        end
        check("stall_latency", t_fault, STALL_TIMEOUT + 1);
        check("stall_flag", bus.stall, 1);
        check("stall_gates", {bus.gate_h, bus.gate_l}, 0);
        pulse_clear();
        check("stall_cleared", bus.stall, 0);
        check("stall_fault_cleared", bus.fault, 0);
        tick(80);
        check("stall_redrive_gate_h", bus.gate_h, 3'b001);

        // asynchronous reset mid-DRIVE
        @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        check("areset_gate_h", bus.gate_h, 0);
        check("areset_gate_l", bus.gate_l, 0);
        check("areset_sector", bus.sector, 7);
        check("areset_position", bus.hall_position, 0);
        @(negedge CLK);
        reset = 1'b0;
        tick(1);
        check("post_reset_sector", bus.sector, 7);
        tick(100);
        check("post_reset_drive_gate_h", bus.gate_h, 3'b001);
        check("post_reset_drive_gate_l", bus.gate_l, 3'b100);

        check("gate_overlap_cycles", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/commutation_sequencer.md
# commutation_sequencer

Six-step BLDC commutation controller for the three-phase gate driver on the motor board. It filters and decodes the three hall sensors, inserts dead time on every drive-pattern change, and latches driver faults and stalls. It tracks signed hall-step position, and drives the six gate-enable lines that the top level gates with the PWM output.

## Interface
- `DEADTIME`, 64: cycles of all-gates-off inserted before any new drive pattern (≥1).
- `HALL_FILTER`, 16: cycles a synchronized hall code must stay stable before acceptance (≥1).
- `STALL_TIMEOUT`, 16_000_000: cycles without an accepted sector change while driving before stall.

Ports:
- `CLK` in 1: system clock (16 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `hall` in 3: raw hall inputs {hall3,hall2,hall1}, asynchronous.
- `enable` in 1: level; 1 = drive the motor.
- `dir` in 1: 1 = forward table, 0 = reverse table.
- `fault_n` in 1: driver fault, active low, asynchronous.
- `clear_fault` in 1: single-cycle pulse; clears sticky flags.
- `gate_h` out 3: high-side enables, bit0=A, bit1=B, bit2=C.
- `gate_l` out 3: low-side enables, same bit order.
- `sector` out 3: accepted sector 0–5; 7 = invalid or unknown.
- `hall_position` out 32 signed: +1 per forward step, −1 per reverse step.
- `hall_error` out 1: sticky; invalid code or skipped sector.
- `stall` out 1: sticky stall flag.
- `fault` out 1: high while in the FAULT state.

## Operation
- **Hall path:** 2-flop synchronizer, then a candidate register. The stability counter restarts whenever the synchronized code differs from the candidate. After `HALL_FILTER` stable cycles the candidate is accepted and decoded.
- **Decode** ({h3,h2,h1}): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. 000 and 111 → 7, which sets `hall_error`.
- **Accepted change s→s':**
  - s'=(s+1)%6: `hall_position` +1.
  - s'=(s+5)%6: `hall_position` −1.
  - Any other jump between valid sectors: set `hall_error`, position unchanged.
  - A transition from 7 into a valid sector does not count.
- **Drive table, dir=1:** 0:HC/LB, 1:HA/LB, 2:HA/LC, 3:HB/LC, 4:HB/LA, 5:HC/LA.
- **Drive table, dir=0:** 0:HB/LC, 1:HB/LA, 2:HC/LA, 3:HC/LB, 4:HA/LB, 5:HA/LC.
- **FSM states:** OFF, DEAD, DRIVE, FAULT. Evaluation priority: fault > !enable > invalid sector > pattern change.
  - **Any state → FAULT:** synchronized `fault_n`=0, or stall counter reaches `STALL_TIMEOUT` (also sets `stall`).
  - **OFF:** gates 0. `enable` && sector≠7 → DEAD, load dead counter.
  - **DEAD:** gates 0, counter decrements.
    - A sector or `dir` change reloads the counter.
    - `!enable` or sector=7 → OFF.
    - Counter expires → DRIVE; (sector, dir) latched at that cycle.
  - **DRIVE:** gates = table(latched sector, latched dir).
    - `!enable` → OFF.
    - sector=7 → OFF.
    - Accepted sector ≠ latched, or `dir` ≠ latched → DEAD.
  - **FAULT:** gates 0, `fault`=1. Exit to OFF only on `clear_fault` && synchronized `fault_n`=1. A `clear_fault` pulse while `fault_n` is still low is ignored.
- **Stall counter:** runs in DEAD/DRIVE, resets on every accepted sector change and in OFF/FAULT, saturates at `STALL_TIMEOUT`.
- **Flag clearing:** `clear_fault` clears `hall_error` and `stall` in any state.
- **Invariant:** `gate_h[i]` and `gate_l[i]` are never both 1. At most one high side and one low side are on at a time.

## Timing
- All outputs are registered.
- **Reset values:**
  - `gate_h`, `gate_l`: 0.
  - `sector`: 7.
  - `hall_position`: 0.
  - `hall_error`, `stall`, `fault`: 0.
  - FSM: OFF.
- **Hall edge → `sector` update:** 2 (sync) + `HALL_FILTER` + 1 cycles.
- **`sector` change → gates 0:** next cycle.
- **Gates 0 → new pattern:** exactly `DEADTIME` cycles.
- **`fault_n` falling → gates 0:** 3 cycles (2 sync + 1).
- **`reset` asserted mid-DRIVE:** gates 0 immediately (asynchronous). After release the FSM resumes from OFF with sector 7.
- **`enable` rising with valid sector:** first drive cycle `DEADTIME`+1 cycles later.

## Structure
- **Package `motor_pkg`:** sector encodings (including INVALID=7), FSM state encoding, and the drive-table function (sector, dir → {gate_h, gate_l}).
- **Sub-module `hall_filter`:** synchronizer, stability counter and decoder. Outputs `sector` plus a one-cycle `sector_changed` strobe.
- **Top of block:** FSM, dead/stall counters, position counter and flags.

## Test plan
- **Forward rotation:** hall sequence 101,100,110,010,011,001 (each held 100 cycles), `enable`=1, `dir`=1 → `hall_position`=5. Each pattern matches the table, each preceded by exactly 64 zero-gate cycles, no `hall_error`.
- **Glitch rejection:** hall glitch to 100 for 10 cycles during 101 (`HALL_FILTER`=16) → `sector` stays 0, gates undisturbed.
- **Invalid and skipped codes:** hall=111 in DRIVE → `sector`=7, gates 0, `hall_error`=1. Separately, 101→110 → `hall_error`=1, position unchanged.
- **Driver fault:** `fault_n`=0 for 5 cycles in DRIVE → gates 0 by cycle 3, `fault`=1.
  - `clear_fault` with `fault_n` still 0 → stays in FAULT.
  - `clear_fault` after `fault_n`=1 → OFF, then DRIVE after 64 dead cycles.
- **Stall:** `STALL_TIMEOUT`=1000, hall held constant while enabled → `stall`=1 and FAULT at cycle 1000.
- **Direction flip:** `dir` toggled in DRIVE → 64 dead cycles, then the reverse-table pattern. Asynchronous `reset` pulse mid-DRIVE → all outputs at reset values within the same cycle.
